// File: rtl/uart_vip_pkg.sv
// Shared definitions for the UART VIP receive path: ASCII constants,
// receive-FSM state encoding and a small saturating-increment helper.
package uart_vip_pkg;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic {
    s_PASS    = 1'b0,
    s_DISCARD = 1'b1
  } rx_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_Clock,
  input  logic             i_Wr_En,
  input  logic [AW-1:0]    i_Wr_Addr,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic [AW-1:0]    i_Rd_Addr,
  output logic [WIDTH-1:0] o_Rd_Data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem_q[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = mem_q[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_line_fifo.sv
// Show-ahead receive FIFO that tags line terminators, counts complete lines
// and, after an overflow, drops bytes until the next terminator fits.
module uart_rx_line_fifo
  import uart_vip_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  LINE_TERM = LF,
  localparam int         CW        = $clog2(DEPTH) + 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst_n,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          o_Data_Valid,
  input  logic          i_Data_Ready,
  output logic [7:0]    o_Data,
  output logic          o_Data_Eol,
  output logic [CW-1:0] o_Count,
  output logic [CW-1:0] o_Lines,
  output logic          o_Line_Avail,
  output logic          o_Full,
  output logic          o_Overflow,
  input  logic          i_Clear_Overflow,
  output logic [15:0]   o_Drop_Count,
  output logic          o_Rx_State
);

  localparam int AW = $clog2(DEPTH);

  // Pop handshake: a pop happens when o_Data_Valid && i_Data_Ready; ready is
  // ignored while empty and valid never depends combinationally on ready.
  rx_state_e      state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  lines_q, lines_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    drops_q, drops_d;

  logic           not_empty;
  logic           is_full;
  logic           pop;
  logic           space;
  logic           push;
  logic           drop;
  logic           eol_in;
  logic [8:0]     head;

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign pop       = not_empty && i_Data_Ready;
  assign space     = !is_full || pop;
  assign eol_in    = (i_Rx_Byte == LINE_TERM);

  // Receive FSM: decides push vs drop for each strobed byte.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      s_PASS: begin
        if (i_Rx_DV) begin
          if (space) begin
            push = 1'b1;
          end else begin
            drop    = 1'b1;
            state_d = s_DISCARD;
          end
        end
      end
      s_DISCARD: begin
        if (i_Rx_DV) begin
          if (eol_in && space) begin
            push    = 1'b1;
            state_d = s_PASS;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = s_PASS;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    lines_d = lines_q;
    unique case ({push && eol_in, pop && head[8]})
      2'b10:   lines_d = lines_q + CW'(1);
      2'b01:   lines_d = lines_q - CW'(1);
      default: lines_d = lines_q;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    ovf_d   = drop ? 1'b1 : (i_Clear_Overflow ? 1'b0 : ovf_q);
    drops_d = drop ? sat_inc16(drops_q) : drops_q;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= s_PASS;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lines_q  <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lines_q  <= lines_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_mem (
    .i_Clock   (i_Clock),
    .i_Wr_En   (push),
    .i_Wr_Addr (wr_ptr_q),
    .i_Wr_Data ({eol_in, i_Rx_Byte}),
    .i_Rd_Addr (rd_ptr_q),
    .o_Rd_Data (head)
  );

  assign o_Data_Valid = not_empty;
  assign o_Data       = head[7:0];
  assign o_Data_Eol   = head[8];
  assign o_Count      = count_q;
  assign o_Lines      = lines_q;
  assign o_Line_Avail = (lines_q != '0);
  assign o_Full       = is_full;
  assign o_Overflow   = ovf_q;
  assign o_Drop_Count = drops_q;
  assign o_Rx_State   = state_q;

endmodule
